// File: rtl/fp_sqrt_pkg.sv
// rtl/fp_sqrt_pkg.sv - shared types, constants and helpers for the binary32 square-root unit
// Contents:
//   state_e      : control FSM encoding
//   special_e    : operand classes whose result bypasses the datapath
//   EXP_BIAS, CANON_QNAN, SQRT_ITERS, SQRT_LATENCY
//   lzc23()      : leading-zero count of a 23-bit fraction
package fp_sqrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_NAN  = 2'd1,
    SP_ZERO = 2'd2,
    SP_INF  = 2'd3
  } special_e;

  localparam int          EXP_BIAS     = 127;
  localparam logic [31:0] CANON_QNAN   = 32'h7FC0_0000;
  localparam int          SQRT_ITERS   = 26;
  localparam int          SQRT_LATENCY = 28;

  // Returns 23 for an all-zero input; the highest set bit wins because it is
  // visited last.
  function automatic logic [4:0] lzc23(input logic [22:0] v);
    logic [4:0] n;
    n = 5'd23;
    for (int i = 0; i < 23; i++) begin
      if (v[i]) n = 5'(22 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_sqrt_core.sv
// rtl/fp_sqrt_core.sv - restoring digit-by-digit integer square root, one root bit per cycle
// Ports:
//   in_Clk, in_Rst_N : clock, synchronous active-low reset
//   start            : load radicand and begin SQRT_ITERS iterations
//   radicand [51:0]  : integer radicand, consumed two bits per iteration from the top
//   done             : high during the cycle whose rising edge completes the last iteration
//   root [25:0]      : integer root (valid once the last iteration has completed)
//   rem_nz           : final remainder is non-zero (sticky)
module fp_sqrt_core
  import fp_sqrt_pkg::*;
(
  input  logic        in_Clk,
  input  logic        in_Rst_N,
  input  logic        start,
  input  logic [51:0] radicand,
  output logic        done,
  output logic [25:0] root,
  output logic        rem_nz
);

  logic [51:0] rad_q;
  logic [27:0] rem_q;
  logic [25:0] root_q;
  logic [4:0]  cnt_q;

  logic [29:0] rem_shift;
  logic [29:0] trial;
  logic        take;

  // The remainder never exceeds 2*root, so 28 bits hold it; the shifted
  // partial remainder and the trial subtrahend need 30.
  always_comb begin
    rem_shift = {rem_q, rad_q[51:50]};
    trial     = {2'b00, root_q, 2'b01};
    take      = (rem_shift >= trial);
  end

  always_ff @(posedge in_Clk) begin
    if (!in_Rst_N) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      rad_q  <= radicand;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= 5'(SQRT_ITERS);
    end else if (cnt_q != 5'd0) begin
      rad_q  <= {rad_q[49:0], 2'b00};
      rem_q  <= take ? 28'(rem_shift - trial) : 28'(rem_shift);
      root_q <= {root_q[24:0], take};
      cnt_q  <= cnt_q - 5'd1;
    end
  end

  assign done   = (cnt_q == 5'd1);
  assign root   = root_q;
  assign rem_nz = |rem_q;

endmodule

// File: rtl/fp_sqrt.sv
// rtl/fp_sqrt.sv - multi-cycle binary32 square root (RNE) with pipeline stall
// Ports:
//   in_Clk, in_Rst_N : clock, synchronous active-low reset
//   in_start         : request, sampled only in IDLE
//   in_data [31:0]   : binary32 operand, latched on acceptance
//   out_data [31:0]  : registered result, held until the next completion
//   out_stall        : high while a request is accepted or computed
module fp_sqrt
  import fp_sqrt_pkg::*;
(
  input  logic        in_Clk,
  input  logic        in_Rst_N,
  input  logic        in_start,
  input  logic [31:0] in_data,
  output logic [31:0] out_data,
  output logic        out_stall
);

  state_e   state_q, state_d;
  special_e special_q, special_d;
  logic       sign_q;
  logic [7:0] exp_q, exp_d;
  logic       accept;

  // Unpack
  logic              op_sign;
  logic [7:0]        op_exp;
  logic [22:0]       op_frac;
  logic [4:0]        shift;
  logic [23:0]       m24;
  logic signed [9:0] e_raw;
  logic signed [9:0] e_even;
  logic signed [9:0] e_half;
  logic [24:0]       m_adj;
  logic [51:0]       radicand;

  // Core
  logic        core_done;
  logic [25:0] core_root;
  logic        core_rem_nz;

  // Round
  logic [23:0] mant;
  logic        round_up;
  logic [24:0] mant_rnd;
  logic [22:0] frac_rnd;
  logic [7:0]  exp_rnd;
  logic [31:0] result;

  assign accept = (state_q == ST_IDLE) && in_start;

  always_comb begin
    op_sign = in_data[31];
    op_exp  = in_data[30:23];
    op_frac = in_data[22:0];
    // Subnormal: shift the leading one up to the hidden-bit position.
    shift   = lzc23(op_frac) + 5'd1;

    if (op_exp == 8'd0) begin
      m24   = {1'b0, op_frac} << shift;
      e_raw = -10'sd126 - $signed({5'b00000, shift});
    end else begin
      m24   = {1'b1, op_frac};
      e_raw = $signed({2'b00, op_exp}) - 10'sd127;
    end

    // An odd exponent is absorbed into the mantissa so the halving is exact;
    // the radicand then spans [1,4) and its root [1,2).
    if (e_raw[0]) begin
      m_adj  = {m24, 1'b0};
      e_even = e_raw - 10'sd1;
    end else begin
      m_adj  = {1'b0, m24};
      e_even = e_raw;
    end
    e_half = e_even >>> 1;
    exp_d  = 8'(e_half + 10'(EXP_BIAS));

    // Radicand scaled by 2^50 so the integer root carries 25 fraction bits.
    radicand = {m_adj, 27'b0};

    if (op_exp == 8'hFF && op_frac != 23'd0)     special_d = SP_NAN;
    else if (op_exp == 8'd0 && op_frac == 23'd0) special_d = SP_ZERO;
    else if (op_sign)                            special_d = SP_NAN;
    else if (op_exp == 8'hFF)                    special_d = SP_INF;
    else                                         special_d = SP_NONE;
  end

  fp_sqrt_core u_core (
    .in_Clk   (in_Clk),
    .in_Rst_N (in_Rst_N),
    .start    (accept),
    .radicand (radicand),
    .done     (core_done),
    .root     (core_root),
    .rem_nz   (core_rem_nz)
  );

  // Root layout: [25] integer, [24:2] fraction, [1] guard, [0] round.
  always_comb begin
    mant     = core_root[25:2];
    round_up = core_root[1] & (core_root[0] | core_rem_nz | mant[0]);
    mant_rnd = {1'b0, mant} + {24'd0, round_up};
    frac_rnd = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];
    exp_rnd  = exp_q + {7'd0, mant_rnd[24]};

    case (special_q)
      SP_NAN:  result = CANON_QNAN;
      SP_ZERO: result = {sign_q, 31'd0};
      SP_INF:  result = 32'h7F80_0000;
      default: result = {1'b0, exp_rnd, frac_rnd};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    out_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_start) begin
          state_d   = ST_CALC;
          out_stall = 1'b1;
        end
      end
      ST_CALC: begin
        out_stall = 1'b1;
        if (core_done) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        out_stall = 1'b1;
        state_d   = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!in_Rst_N) out_stall = 1'b0;
  end

  always_ff @(posedge in_Clk) begin
    if (!in_Rst_N) begin
      state_q   <= ST_IDLE;
      special_q <= SP_NONE;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      out_data  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        special_q <= special_d;
        sign_q    <= op_sign;
        exp_q     <= exp_d;
      end
      if (state_q == ST_ROUND) out_data <= result;
    end
  end

endmodule

// File: tb/tb_fp_sqrt.sv
// tb/tb_fp_sqrt.sv - directed scoreboard bench for fp_sqrt
module tb_fp_sqrt;
  import fp_sqrt_pkg::*;

  logic        in_Clk   = 1'b0;
  logic        in_Rst_N = 1'b0;
  logic        in_start = 1'b0;
  logic [31:0] in_data  = 32'd0;
  logic [31:0] out_data;
  logic        out_stall;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = 32'd0;

  fp_sqrt dut (
    .in_Clk    (in_Clk),
    .in_Rst_N  (in_Rst_N),
    .in_start  (in_start),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_stall (out_stall)
  );

  always #5 in_Clk = ~in_Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
  endtask

  // Drives one request and follows it to DONE. Called just after a rising
  // edge with the unit in IDLE; returns just after the DONE edge.
  task automatic run_op(input string tag, input logic [31:0] opnd,
                        input logic [31:0] expv, input bit hold);
    int          stalls;
    bit          done;
    bit          stable;
    logic [31:0] want;
    in_data  = opnd;
    in_start = 1'b1;
    exp_q.push_back(expv);
    stalls = 0;
    done   = 1'b0;
    stable = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge in_Clk);
      if (out_stall) begin
        stalls++;
        if (out_data !== last_res) stable = 1'b0;
      end else begin
        done = 1'b1;
      end
      if (!done) begin
        @(posedge in_Clk);
        #1;
        if (!hold) in_start = 1'b0;
        in_data = $urandom();
      end
    end
    check({tag, " stall"}, 32'(stalls), 32'(SQRT_LATENCY));
    check({tag, " stable"}, 32'(stable), 32'd1);
    if (exp_q.size() != 0) want = exp_q.pop_front();
    else want = 32'hxxxx_xxxx;
    check(tag, out_data, want);
    last_res = expv;
    @(posedge in_Clk);
    #1;
  endtask

  initial begin
    in_Rst_N = 1'b0;
    in_start = 1'b1;
    in_data  = 32'h4080_0000;
    repeat (2) @(posedge in_Clk);
    @(negedge in_Clk);
    check("rst stall", {31'd0, out_stall}, 32'd0);
    check("rst data", out_data, 32'd0);
    @(posedge in_Clk);
    #1;
    in_Rst_N = 1'b1;

    run_op("sqrt4 held", 32'h4080_0000, 32'h4000_0000, 1'b1);
    run_op("sqrt9 held", 32'h4110_0000, 32'h4040_0000, 1'b0);
    run_op("sqrt2",      32'h4000_0000, 32'h3FB5_04F3, 1'b0);
    run_op("neg1",       32'hBF80_0000, CANON_QNAN,    1'b0);
    run_op("snan",       32'h7FA0_0000, CANON_QNAN,    1'b0);
    run_op("pinf",       32'h7F80_0000, 32'h7F80_0000, 1'b0);
    run_op("nzero",      32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op("pzero",      32'h0000_0000, 32'h0000_0000, 1'b0);
    run_op("subnorm",    32'h0000_0001, 32'h1A35_04F3, 1'b0);
    run_op("maxnorm",    32'h7F7F_FFFF, 32'h5F7F_FFFF, 1'b0);
    run_op("half",       32'h3F00_0000, 32'h3F35_04F3, 1'b0);
    run_op("sqrt16",     32'h4180_0000, 32'h4080_0000, 1'b0);
    run_op("ninf",       32'hFF80_0000, CANON_QNAN,    1'b0);
    run_op("qnan",       32'h7FC0_0001, CANON_QNAN,    1'b0);
    run_op("nsubnorm",   32'h8000_0001, CANON_QNAN,    1'b0);

    // Reset at the tenth CALC cycle aborts the operation.
    in_data  = 32'h4000_0000;
    in_start = 1'b1;
    @(posedge in_Clk);
    #1;
    in_start = 1'b0;
    check("abort busy", {31'd0, out_stall}, 32'd1);
    repeat (9) @(posedge in_Clk);
    #1;
    in_Rst_N = 1'b0;
    @(posedge in_Clk);
    #1;
    check("abort stall", {31'd0, out_stall}, 32'd0);
    check("abort data", out_data, 32'd0);
    in_Rst_N = 1'b1;
    @(negedge in_Clk);
    check("abort idle", {31'd0, out_stall}, 32'd0);
    check("abort data2", out_data, 32'd0);
    last_res = 32'd0;
    @(posedge in_Clk);
    #1;
    run_op("restart4", 32'h4080_0000, 32'h4000_0000, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fp_sqrt.md
# fp_sqrt

Multi-cycle IEEE-754 single-precision square-root unit for the RV64IF floating-point datapath, serving FSQRT.S. A start request latches the operand. The unit computes the root iteratively, one result bit per cycle. It holds `out_stall` high so the pipeline freezes until the correctly rounded result appears on `out_data`.

## Interface
- No parameters. Latency and iteration count are fixed constants, listed under Structure.
- `in_Clk` in 1: single clock; all state updates on the rising edge.
- `in_Rst_N` in 1: synchronous, active-low reset.
- `in_start` in 1: request to start a square root; sampled only in IDLE.
- `in_data` in 32: operand, binary32; latched when a start is accepted.
- `out_data` out 32: result, binary32; registered; holds the last result until the next completion.
- `out_stall` out 1: high while a request is being accepted or computed.

## Operation
- States:
  - IDLE: accept and unpack the operand.
  - CALC: 26 iterations.
  - ROUND: round and pack.
  - DONE: 1 cycle, then back to IDLE.
- IDLE:
  - If `in_start`=1, latch `in_data`, classify it, unpack it, and go to CALC.
  - Otherwise stay in IDLE.
- Unpack:
  - Sign s, exponent E, fraction f.
  - Normal: m=1.f and e=E−127.
  - Subnormal: normalise with a leading-zero count; m=1.x and e=−126−shift.
  - If e is odd, set m=m·2 and e=e−1.
  - Result exponent = e/2+127; it never overflows or underflows.
- CALC: restoring digit-by-digit integer square root, one result bit per cycle.
  - 26 bits are produced: 1 integer bit, 23 fraction bits, guard, round.
  - Sticky = final remainder ≠ 0.
  - The root always lies in [1,2), so no renormalisation is needed.
- ROUND:
  - Round to nearest, ties to even.
  - A mantissa carry-out increments the exponent.
  - Write `out_data`.
- Special operands all take the same fixed latency; the datapath result is overridden in ROUND.
  - NaN (quiet or signalling) → 0x7FC00000.
  - Negative non-zero, including −inf → 0x7FC00000.
  - ±0 → ±0, sign preserved.
  - +inf → +inf.
- Only RNE is supported; no rounding-mode input and no exception-flag outputs.
- Changes on `in_data` after acceptance are ignored.

## Timing
- Reset (`in_Rst_N`=0 at a rising edge):
  - state=IDLE, `out_data`=0x00000000, `out_stall`=0.
  - Reset mid-operation aborts the operation; no result is written.
  - While reset is low, `out_stall`=0 regardless of `in_start`.
- `out_stall` is combinational: (state==IDLE && `in_start`) || state==CALC || state==ROUND.
  - Accept cycle T: stall=1.
  - T+1..T+26: CALC.
  - T+27: ROUND.
  - T+28: DONE, stall=0, `out_data` valid.
- Stall is high for exactly 28 cycles per operation; the result is visible 28 cycles after the accept edge.
- If `in_start` is held high, the IDLE cycle after DONE accepts a new operation.
  - Stall pattern: 28 high, 1 low (DONE), repeat.
  - `out_data` is stable across restarts until the next ROUND.

## Structure
- Shared package `fp_sqrt_pkg`:
  - state encoding;
  - `EXP_BIAS`=127;
  - `CANON_QNAN`=32'h7FC00000;
  - `SQRT_ITERS`=26;
  - `SQRT_LATENCY`=28.
- One natural sub-module, `fp_sqrt_core`.
  - Iterative radicand/remainder/root registers with a bit counter.
  - Start/done interface.
- The top level owns unpacking, special-case classification, rounding and the FSM.

## Test plan
- 0x40800000 (4.0) with `in_start` held after reset release → `out_stall` high 28 cycles, then `out_data`=0x40000000.
- 0x40000000 (2.0) → 0x3FB504F3; 0x41100000 (9.0) → 0x40400000.
- 0xBF800000 (−1.0) → 0x7FC00000; 0x7FA00000 (sNaN) → 0x7FC00000; 0x7F800000 (+inf) → 0x7F800000.
- 0x80000000 (−0) → 0x80000000; 0x00000000 → 0x00000000.
- Subnormal 0x00000001 → 0x1A3504F3, same 28-cycle latency.
- Assert `in_Rst_N`=0 at cycle 10 of CALC → next cycle IDLE, stall=0, `out_data`=0.
  - Then restart with 4.0 → 0x40000000 after 28 cycles.
